// File: rtl/lane_traffic.sv
// Lane controller for a row of cars that share one road lane. It spawns the cars one
// after another, animates and moves them, and wraps them at the playfield edges.
// It also resolves the raster pixel and the per-player foot collisions against the active cars.
module lane_traffic #(
   parameter int NUM_CARS        = 4,
   parameter int NUM_PLAYERS     = 2,
   parameter int CAR_WIDTH       = 48,
   parameter int CAR_HEIGHT      = 26,
   parameter int MIN_X           = 100,
   parameter int MAX_X           = 739,
   parameter int TILES_PER_ANIM  = 4,
   parameter int FRAMES_PER_TILE = 5,
   parameter int MOVE_DIV        = 2
) (
   input  logic                           FrameClk,
   input  logic                           Reset,
   input  logic                           LaneEnable,
   input  logic                           FaceLeft,
   input  logic [1:0]                     Type,
   input  logic [2:0]                     Speed,
   input  logic [7:0]                     SpawnGap,
   input  logic [9:0]                     SpawnX,
   input  logic [9:0]                     SpawnY,
   input  logic [9:0]                     DrawX,
   input  logic [9:0]                     DrawY,
   input  logic [NUM_PLAYERS*10-1:0]      PX,
   input  logic [NUM_PLAYERS*10-1:0]      PY,
   input  logic [NUM_PLAYERS*5-1:0]       PHbOffset,
   output logic [NUM_PLAYERS-1:0]         PHit,
   output logic                           CarPixel,
   output logic [3:0]                     Tile,
   output logic [5:0]                     PixelX,
   output logic [4:0]                     PixelY,
   output logic [$clog2(NUM_CARS+1)-1:0]  ActiveCount
);

   localparam int IDX_W  = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
   localparam int CNT_W  = $clog2(NUM_CARS + 1);
   localparam int FRM_W  = (FRAMES_PER_TILE > 1) ? $clog2(FRAMES_PER_TILE) : 1;
   localparam int TILE_W = (TILES_PER_ANIM > 1) ? $clog2(TILES_PER_ANIM) : 1;
   localparam int MOV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

   localparam logic [9:0]        WIDTH10   = 10'(CAR_WIDTH);
   localparam logic [9:0]        MIN10     = 10'(MIN_X);
   localparam logic [9:0]        MAX10     = 10'(MAX_X);
   localparam logic [9:0]        LEFT_ENT  = 10'(MAX_X + 1);
   localparam logic [9:0]        RIGHT_ENT = 10'(MIN_X - CAR_WIDTH - 1);
   localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(FRAMES_PER_TILE - 1);
   localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILES_PER_ANIM - 1);
   localparam logic [MOV_W-1:0]  MOV_LAST  = MOV_W'(MOVE_DIV - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SPAWNING = 2'd1, RUNNING = 2'd2} state_t;

   state_t              state_r;
   logic [9:0]          x_r [NUM_CARS];
   logic [NUM_CARS-1:0] active_r;
   logic [7:0]          gap_r;
   logic [IDX_W-1:0]    spawn_idx_r;
   logic [FRM_W-1:0]    frame_r;
   logic [TILE_W-1:0]   tile_r;
   logic [MOV_W-1:0]    move_r;

   logic [7:0]          gap_last_s;
   logic [NUM_CARS-1:0] car_hit_s;
   logic [9:0]          sel_x_s;
   logic [9:0]          dx_s;
   logic [NUM_PLAYERS-1:0] hit_s;
   logic [CNT_W-1:0]    count_s;

   // Wrapping is decided on the pre-move X and wins over the step; all of it is modulo 1024.
   function automatic logic [9:0] step_x(input logic [9:0] x, input logic left, input logic [2:0] spd);
      logic [9:0] r;
      if (left) begin
         r = (x + WIDTH10 < MIN10) ? LEFT_ENT : x - {7'd0, spd};
      end else begin
         r = (x >= MAX10) ? RIGHT_ENT : x + {7'd0, spd};
      end
      return r;
   endfunction

   // Strict-inequality span overlap; 11 bits so edges past 1023 never alias.
   function automatic logic overlap_1d(input logic [10:0] a, input logic [10:0] wa,
                                       input logic [10:0] b, input logic [10:0] wb);
      return (a < b + wb) && (b < a + wa);
   endfunction

   // Spawn spacing: a zero gap behaves like one frame.
   always_comb begin
      gap_last_s = (SpawnGap == 8'd0) ? 8'd0 : SpawnGap - 8'd1;
   end

   // Lane FSM with the spawn, animation and movement counters.
   always_ff @(posedge FrameClk or posedge Reset) begin
      if (Reset) begin
         state_r     <= IDLE;
         active_r    <= '0;
         gap_r       <= 8'd0;
         spawn_idx_r <= '0;
         frame_r     <= '0;
         tile_r      <= '0;
         move_r      <= '0;
         for (int i = 0; i < NUM_CARS; i++) x_r[i] <= 10'd0;
      end else if (!LaneEnable) begin
         state_r     <= IDLE;
         active_r    <= '0;
         gap_r       <= 8'd0;
         spawn_idx_r <= '0;
         frame_r     <= '0;
         tile_r      <= '0;
         move_r      <= '0;
      end else begin
         if (state_r != IDLE) begin
            if (frame_r == FRM_LAST) begin
               frame_r <= '0;
               tile_r  <= (tile_r == TILE_LAST) ? '0 : tile_r + TILE_W'(1);
            end else begin
               frame_r <= frame_r + FRM_W'(1);
            end
            move_r <= (move_r == MOV_LAST) ? '0 : move_r + MOV_W'(1);
            // Only cars already active before this edge move; a spawn below overrides its slot.
            if (move_r == '0) begin
               for (int i = 0; i < NUM_CARS; i++) begin
                  if (active_r[i]) x_r[i] <= step_x(x_r[i], FaceLeft, Speed);
               end
            end
         end
         case (state_r)
            IDLE: begin
               active_r[0] <= 1'b1;
               x_r[0]      <= SpawnX;
               gap_r       <= 8'd0;
               spawn_idx_r <= IDX_W'(1);
               state_r     <= (NUM_CARS == 1) ? RUNNING : SPAWNING;
            end
            SPAWNING: begin
               if (gap_r == gap_last_s) begin
                  active_r[spawn_idx_r] <= 1'b1;
                  x_r[spawn_idx_r]      <= SpawnX;
                  gap_r                 <= 8'd0;
                  if (spawn_idx_r == IDX_W'(NUM_CARS - 1)) state_r <= RUNNING;
                  else spawn_idx_r <= spawn_idx_r + IDX_W'(1);
               end else begin
                  gap_r <= gap_r + 8'd1;
               end
            end
            RUNNING: state_r <= RUNNING;
            default: state_r <= IDLE;
         endcase
      end
   end

   // Raster hit test, lowest-index car wins, plus per-player foot collisions.
   always_comb begin
      car_hit_s = '0;
      sel_x_s   = 10'd0;
      hit_s     = '0;
      count_s   = '0;
      for (int i = 0; i < NUM_CARS; i++) begin
         car_hit_s[i] = active_r[i]
                      & overlap_1d({1'b0, DrawX}, 11'd1, {1'b0, x_r[i]}, 11'(CAR_WIDTH))
                      & overlap_1d({1'b0, DrawY}, 11'd1, {1'b0, SpawnY}, 11'(CAR_HEIGHT));
         count_s = count_s + CNT_W'(active_r[i]);
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            hit_s[p] = hit_s[p] | (active_r[i]
               & overlap_1d({1'b0, PX[10*p +: 10]} + {6'd0, PHbOffset[5*p +: 5]}, 11'd16,
                            {1'b0, x_r[i]}, 11'(CAR_WIDTH))
               & overlap_1d({1'b0, PY[10*p +: 10]} + 11'd30, 11'd1,
                            {1'b0, SpawnY} + 11'(CAR_HEIGHT - 16), 11'd16));
         end
      end
      for (int i = NUM_CARS - 1; i >= 0; i--) begin
         sel_x_s = car_hit_s[i] ? x_r[i] : sel_x_s;
      end
      dx_s = DrawX - sel_x_s;
   end

   assign CarPixel    = |car_hit_s;
   assign PixelX      = !CarPixel ? 6'd0 : (FaceLeft ? dx_s[5:0] : 6'(CAR_WIDTH - 1) - dx_s[5:0]);
   assign PixelY      = CarPixel ? 5'(DrawY - SpawnY) : 5'd0;
   assign PHit        = LaneEnable ? hit_s : '0;
   assign Tile        = 4'(int'(Type) * TILES_PER_ANIM + int'(tile_r));
   assign ActiveCount = count_s;

endmodule

// File: tb/tb_lane_traffic.sv
// Randomized bench for lane_traffic. A frame-schedule reference model predicts the cars
// from the number of enabled frames, and raster, collision and counter outputs are checked against it.
module tb_lane_traffic;
   localparam int NC = 4;
   localparam int NP = 2;

   logic FrameClk = 1'b0;
   logic Reset, LaneEnable, FaceLeft;
   logic [1:0] Type;
   logic [2:0] Speed;
   logic [7:0] SpawnGap;
   logic [9:0] SpawnX, SpawnY, DrawX, DrawY;
   logic [NP*10-1:0] PX, PY;
   logic [NP*5-1:0]  PHbOffset;
   logic [NP-1:0] PHit;
   logic CarPixel;
   logic [3:0] Tile;
   logic [5:0] PixelX;
   logic [4:0] PixelY;
   logic [2:0] ActiveCount;

   lane_traffic dut (
      .FrameClk(FrameClk), .Reset(Reset), .LaneEnable(LaneEnable), .FaceLeft(FaceLeft),
      .Type(Type), .Speed(Speed), .SpawnGap(SpawnGap), .SpawnX(SpawnX), .SpawnY(SpawnY),
      .DrawX(DrawX), .DrawY(DrawY), .PX(PX), .PY(PY), .PHbOffset(PHbOffset),
      .PHit(PHit), .CarPixel(CarPixel), .Tile(Tile), .PixelX(PixelX), .PixelY(PixelY),
      .ActiveCount(ActiveCount));

   always #5 FrameClk = ~FrameClk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: session flag, enabled-edge index, gap, cars spawned so far, car positions.
   bit m_sess;
   int m_e, m_g, m_nsp;
   int m_x [NC];
   bit m_act [NC];

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wrap10(input int v);
      return ((v % 1024) + 1024) % 1024;
   endfunction

   function automatic int next_x(input int x, input bit left, input int spd);
      if (left) return (wrap10(x + 48) < 100) ? 740 : wrap10(x - spd);
      return (x >= 739) ? 51 : wrap10(x + spd);
   endfunction

   task automatic model_clear();
      m_sess = 1'b0;
      foreach (m_act[k]) m_act[k] = 1'b0;
   endtask

   // Car k appears on enabled edge k*gap; cars move on enabled edges 1, 3, 5, ...
   task automatic model_edge();
      if (!LaneEnable) begin
         model_clear();
      end else if (!m_sess) begin
         m_sess = 1'b1; m_e = 0; m_nsp = 1;
         m_g = (SpawnGap == 8'd0) ? 1 : int'(SpawnGap);
         m_act[0] = 1'b1; m_x[0] = int'(SpawnX);
      end else begin
         m_e++;
         if ((m_e - 1) % 2 == 0)
            for (int k = 0; k < NC; k++) if (m_act[k]) m_x[k] = next_x(m_x[k], FaceLeft, int'(Speed));
         if (m_nsp < NC && m_e == m_nsp * m_g) begin
            m_act[m_nsp] = 1'b1; m_x[m_nsp] = int'(SpawnX); m_nsp++;
         end
      end
   endtask

   task automatic frame();
      model_edge();
      @(posedge FrameClk);
      #1;
   endtask

   task automatic check_frame(input string tag);
      int cnt;
      cnt = 0;
      foreach (m_act[k]) cnt += int'(m_act[k]);
      check_val({tag, "_count"}, int'(ActiveCount), cnt);
      check_val({tag, "_tile"}, int'(Tile), (int'(Type) * 4 + (m_sess ? (m_e / 5) % 4 : 0)) % 16);
   endtask

   task automatic check_raster(input string tag);
      int ep, epx, epy, eh, d, pxh, pyf, cy;
      ep = 0; epx = 0; epy = 0; eh = 0;
      for (int k = 0; k < NC; k++) begin
         if (ep == 0 && m_act[k] && m_x[k] <= int'(DrawX) && int'(DrawX) < m_x[k] + 48 &&
             int'(SpawnY) <= int'(DrawY) && int'(DrawY) < int'(SpawnY) + 26) begin
            ep = 1; d = int'(DrawX) - m_x[k];
            epx = FaceLeft ? d : 47 - d;
            epy = int'(DrawY) - int'(SpawnY);
         end
      end
      cy = int'(SpawnY) + 10;
      for (int p = 0; p < NP; p++) begin
         pxh = int'(PX[10*p +: 10]) + int'(PHbOffset[5*p +: 5]);
         pyf = int'(PY[10*p +: 10]) + 30;
         for (int k = 0; k < NC; k++)
            if (m_act[k] && pxh < m_x[k] + 48 && m_x[k] < pxh + 16 && pyf < cy + 16 && cy < pyf + 1)
               eh = eh | (1 << p);
      end
      if (!LaneEnable) eh = 0;
      check_val({tag, "_carpixel"}, int'(CarPixel), ep);
      check_val({tag, "_pixelx"}, int'(PixelX), epx);
      check_val({tag, "_pixely"}, int'(PixelY), epy);
      check_val({tag, "_phit"}, int'(PHit), eh);
   endtask

   // Raster and players are placed around a chosen car so hits and near-misses both occur.
   task automatic random_raster(input string tag);
      int base;
      base = m_x[$urandom_range(0, NC - 1)];
      DrawX = 10'(wrap10(base + int'($urandom_range(0, 60)) - 6));
      DrawY = 10'(wrap10(int'(SpawnY) + int'($urandom_range(0, 32)) - 3));
      for (int p = 0; p < NP; p++) begin
         PX[10*p +: 10]      = 10'(wrap10(base + int'($urandom_range(0, 80)) - 40));
         PY[10*p +: 10]      = 10'(wrap10(int'(SpawnY) - 23 + int'($urandom_range(0, 24))));
         PHbOffset[5*p +: 5] = 5'($urandom_range(0, 31));
      end
      #1;
      check_raster(tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1; LaneEnable = 1'b0; FaceLeft = 1'b1; Type = 2'd2; Speed = 3'd2;
      SpawnGap = 8'd10; SpawnX = 10'd700; SpawnY = 10'd200; DrawX = 10'd700; DrawY = 10'd205;
      PX = '0; PY = '0; PHbOffset = '0;
      model_clear();
      #12;
      check_val("reset_count", int'(ActiveCount), 0);
      check_val("reset_phit", int'(PHit), 0);
      check_val("reset_carpixel", int'(CarPixel), 0);
      check_val("reset_pixelx", int'(PixelX), 0);
      check_val("reset_pixely", int'(PixelY), 0);
      @(negedge FrameClk);
      Reset = 1'b0;

      // Staggered spawn and Type=2 tile sequence.
      LaneEnable = 1'b1;
      for (int f = 0; f < 40; f++) begin
         frame();
         check_frame("spawn");
         check_val("tile_seq", int'(Tile), 8 + (f / 5) % 4);
         if (f % 10 == 0) check_val("spawn_step", int'(ActiveCount), f / 10 + 1);
         random_raster("spawn");
      end
      LaneEnable = 1'b0;
      frame();
      check_frame("disable");

      // Left wrap: 51+48 < 100 so the first move re-enters at 740.
      SpawnX = 10'd51; FaceLeft = 1'b1; Speed = 3'd1; SpawnGap = 8'd200; LaneEnable = 1'b1;
      frame(); frame();
      check_frame("wrapl");
      DrawX = 10'd740; DrawY = SpawnY; #1;
      check_val("wrapl_carpixel", int'(CarPixel), 1);
      check_val("wrapl_pixelx", int'(PixelX), 0);
      DrawX = 10'd60; #1;
      check_val("wrapl_old_spot", int'(CarPixel), 0);
      LaneEnable = 1'b0;
      frame();

      // Right wrap: 739 re-enters at 51; FaceLeft=0 mirrors the column.
      SpawnX = 10'd739; FaceLeft = 1'b0; LaneEnable = 1'b1;
      frame(); frame();
      check_frame("wrapr");
      DrawX = 10'd51; DrawY = SpawnY + 10'd5; #1;
      check_val("wrapr_carpixel", int'(CarPixel), 1);
      check_val("wrapr_pixelx", int'(PixelX), 47);
      check_val("wrapr_pixely", int'(PixelY), 5);
      LaneEnable = 1'b0;
      frame();

      // Foot collision against stationary cars at X=180.
      SpawnX = 10'd180; Speed = 3'd0; SpawnGap = 8'd1; FaceLeft = 1'b1; LaneEnable = 1'b1;
      for (int f = 0; f < 5; f++) begin frame(); check_frame("coll"); end
      PX = {10'd900, 10'd200}; PY = {10'd0, SpawnY - 10'd20}; PHbOffset = {5'd0, 5'd8}; #1;
      check_val("coll_p0_hit", int'(PHit), 1);
      PY[9:0] = SpawnY - 10'd31; #1;
      check_val("coll_p0_miss", int'(PHit), 0);
      PX[19:10] = 10'd200; PY[19:10] = SpawnY - 10'd20; PHbOffset[9:5] = 5'd8; #1;
      check_val("coll_p1_hit", int'(PHit), 2);
      DrawX = 10'd190; DrawY = SpawnY;
      // Asynchronous reset between edges clears everything at once.
      #2 Reset = 1'b1;
      #1;
      model_clear();
      check_val("areset_count", int'(ActiveCount), 0);
      check_val("areset_carpixel", int'(CarPixel), 0);
      check_val("areset_phit", int'(PHit), 0);
      @(negedge FrameClk);
      Reset = 1'b0;

      // LaneEnable drop while still spawning.
      SpawnX = 10'd400; Speed = 3'd3; SpawnGap = 8'd5; LaneEnable = 1'b1;
      for (int f = 0; f < 7; f++) begin frame(); check_frame("drop"); end
      DrawX = 10'(m_x[0]); DrawY = SpawnY; PX[9:0] = 10'(m_x[0]); PY[9:0] = SpawnY - 10'd20; #1;
      check_raster("drop_pre");
      LaneEnable = 1'b0;
      frame();
      check_val("drop_count", int'(ActiveCount), 0);
      check_val("drop_carpixel", int'(CarPixel), 0);
      check_val("drop_phit", int'(PHit), 0);

      // Random sessions with live changes to direction, type, speed, row and entry X.
      for (int s = 0; s < 12; s++) begin
         int len;
         SpawnGap = 8'($urandom_range(0, 6));
         SpawnX = 10'($urandom_range(0, 1023));
         SpawnY = 10'($urandom_range(0, 1000));
         FaceLeft = 1'($urandom_range(0, 1));
         Type = 2'($urandom_range(0, 3));
         Speed = 3'($urandom_range(0, 7));
         LaneEnable = 1'b1;
         len = int'($urandom_range(20, 60));
         for (int f = 0; f < len; f++) begin
            if ($urandom_range(0, 3) == 0) FaceLeft = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) Type = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) Speed = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) SpawnY = 10'($urandom_range(0, 1000));
            if ($urandom_range(0, 3) == 0) SpawnX = 10'($urandom_range(0, 1023));
            frame();
            check_frame("rnd");
            random_raster("rnd_a");
            random_raster("rnd_b");
         end
         if (s % 3 == 2) begin
            #2 Reset = 1'b1;
            #1;
            model_clear();
            check_val("rnd_areset_count", int'(ActiveCount), 0);
            check_val("rnd_areset_carpixel", int'(CarPixel), 0);
            @(negedge FrameClk);
            Reset = 1'b0;
         end else begin
            LaneEnable = 1'b0;
            frame();
            check_frame("rnd_off");
            random_raster("rnd_off");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
